// File: rtl/shot_clock_timer.sv
// -----------------------------------------------------------------------------
// shot_clock_timer
//
// Two-digit BCD countdown timer for the basketball shot clock. It drives the
// d1/d0 digit inputs and the scan_en strobe of the downstream sevenseg_mux.
//
// The count steps down once every TICK_DIV clocks while running and is
// controlled by one-cycle start / pause / reload pulses.
// Priority when pulses coincide: reload > pause > start.
//
// Parameters
//   TICK_DIV  : clk cycles per countdown step (>= 2, even)
//   SCAN_DIV  : clk cycles between scan_en pulses
//   START_VAL : decimal preset loaded on reset / reload (0..99)
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   start        in   pulse: begin / resume counting
//   pause        in   pulse: freeze counting (fraction of second kept)
//   reload       in   pulse: load START_VAL and stop
//   d1           out  tens digit, 4'hF = blank
//   d0           out  ones digit, 4'hF = blank
//   scan_en      out  one-cycle strobe every SCAN_DIV cycles
//   running      out  high while counting
//   expired      out  high while expired
//   expire_pulse out  one-cycle pulse on entry to the expired state
//   dbg_state    out  current FSM state (IDLE=0, RUN=1, PAUSED=2, EXPIRED=3)
//
// Optional feature
//   SHOT_CLOCK_FLASH_EN : when defined, the expired display alternates
//   "00" and blank every TICK_DIV/2 cycles, starting with "00". When not
//   defined the expired display is a steady "00" and no flash counter exists.
//
// Handshake note: start/pause/reload are plain level-sampled pulses; each
// cycle they are high counts as one request. There is no back-pressure.
// -----------------------------------------------------------------------------
module shot_clock_timer #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int SCAN_DIV  = 100_000,
    parameter int START_VAL = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       reload,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       scan_en,
    output logic       running,
    output logic       expired,
    output logic       expire_pulse,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

    localparam logic [3:0] PRE_TENS = 4'(START_VAL / 10);
    localparam logic [3:0] PRE_ONES = 4'(START_VAL % 10);
    // Reset display: leading zero of the preset is blanked.
    localparam logic [3:0] PRE_D1   = (PRE_TENS == 4'd0) ? 4'hF : PRE_TENS;

    state_t          state_q, state_d;
    logic [3:0]      tens_q, tens_d;
    logic [3:0]      ones_q, ones_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [SW-1:0]   scan_cnt_q;
    logic [3:0]      disp_d1, disp_d0;
    logic            count_zero;

    assign count_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
    assign dbg_state  = state_q;

`ifdef SHOT_CLOCK_FLASH_EN
    localparam int HALF = TICK_DIV / 2;
    localparam int FW   = (HALF > 2) ? $clog2(HALF) : 1;
    localparam logic [FW-1:0] FLASH_MAX = FW'(HALF - 1);

    logic [FW-1:0] flash_cnt_q;
    logic          flash_ph_q;   // 0 = show "00", 1 = blank
`endif

    // -------------------------------------------------------------------------
    // Next-state and count logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        presc_d = presc_q;

        if (reload) begin
            state_d = S_IDLE;
            tens_d  = PRE_TENS;
            ones_d  = PRE_ONES;
            presc_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // pause outranks start; on its own it does nothing here
                    if (!pause && start) begin
                        if (count_zero) begin
                            state_d = S_EXPIRED;
                        end else begin
                            state_d = S_RUN;
                            presc_d = '0;
                        end
                    end
                end

                S_RUN: begin
                    if (pause) begin
                        // presc is left untouched so the partial second resumes
                        state_d = S_PAUSED;
                    end else if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        // BCD borrow: never treat the count as a binary number
                        if (ones_q != 4'd0) begin
                            ones_d = ones_q - 4'd1;
                        end else begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end
                        // Stepping down from 01 lands on 00
                        if (tens_q == 4'd0 && ones_q == 4'd1) begin
                            state_d = S_EXPIRED;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end

                S_PAUSED: begin
                    if (!pause && start) begin
                        state_d = S_RUN;
                    end
                end

                S_EXPIRED: begin
                    // Only reload or rst leave this state.
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Display mapping, taken from the current (registered) count so the
    // digits follow the count one cycle later.
    // -------------------------------------------------------------------------
    always_comb begin
        disp_d1 = (tens_q == 4'd0) ? 4'hF : tens_q;
        disp_d0 = ones_q;
        if (state_q == S_EXPIRED) begin
`ifdef SHOT_CLOCK_FLASH_EN
            if (flash_ph_q) begin
                disp_d1 = 4'hF;
                disp_d0 = 4'hF;
            end else begin
                disp_d1 = 4'd0;
                disp_d0 = 4'd0;
            end
`else
            disp_d1 = 4'd0;
            disp_d0 = 4'd0;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // State, counters and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tens_q       <= PRE_TENS;
            ones_q       <= PRE_ONES;
            presc_q      <= '0;
            scan_cnt_q   <= '0;
            scan_en      <= 1'b0;
            running      <= 1'b0;
            expired      <= 1'b0;
            expire_pulse <= 1'b0;
            d1           <= PRE_D1;
            d0           <= PRE_ONES;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            presc_q <= presc_d;

            // Status flags follow the state being entered on this edge.
            running      <= (state_d == S_RUN);
            expired      <= (state_d == S_EXPIRED);
            expire_pulse <= (state_d == S_EXPIRED) && (state_q != S_EXPIRED);

            d1 <= disp_d1;
            d0 <= disp_d0;

            // Digit-scan strobe runs regardless of the FSM.
            if (scan_cnt_q == SCAN_MAX) begin
                scan_cnt_q <= '0;
                scan_en    <= 1'b1;
            end else begin
                scan_cnt_q <= scan_cnt_q + 1'b1;
                scan_en    <= 1'b0;
            end
        end
    end

`ifdef SHOT_CLOCK_FLASH_EN
    // Flash phase timer: idle at zero outside EXPIRED, so the first visible
    // phase after entry is always "00" for a full half period.
    always_ff @(posedge clk) begin
        if (rst || reload || state_q != S_EXPIRED) begin
            flash_cnt_q <= '0;
            flash_ph_q  <= 1'b0;
        end else if (flash_cnt_q == FLASH_MAX) begin
            flash_cnt_q <= '0;
            flash_ph_q  <= ~flash_ph_q;
        end else begin
            flash_cnt_q <= flash_cnt_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_shot_clock_timer.sv
// -----------------------------------------------------------------------------
// Bench for shot_clock_timer (TICK_DIV=8, SCAN_DIV=4, START_VAL=10).
// A reference model holds the count as a plain integer, plus elapsed-cycle
// counters, and predicts every output each cycle; directed pulses exercise
// countdown, expiry, pause/resume, coincident pulses and mid-run reset.
// -----------------------------------------------------------------------------
module tb_shot_clock_timer;

    localparam int TICK_DIV  = 8;
    localparam int SCAN_DIV  = 4;
    localparam int START_VAL = 10;

`ifdef SHOT_CLOCK_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_PAUSED  = 2;
    localparam int M_EXPIRED = 3;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic start  = 1'b0;
    logic pause  = 1'b0;
    logic reload = 1'b0;

    logic [3:0] d1, d0;
    logic       scan_en, running, expired, expire_pulse;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    shot_clock_timer #(
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV),
        .START_VAL(START_VAL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pause       (pause),
        .reload      (reload),
        .d1          (d1),
        .d0          (d0),
        .scan_en     (scan_en),
        .running     (running),
        .expired     (expired),
        .expire_pulse(expire_pulse),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int   m_val, m_mode, m_frac, m_scan_age, m_exp_age, old_mode;
    bit   m_valid = 1'b0;
    logic [3:0] e_d1, e_d0;
    logic e_scan, e_run, e_exp, e_pulse;

    // What the two digits must show for a given count / mode / time spent expired.
    function automatic logic [7:0] show(input int val, input int mode, input int age);
        int tens;
        int phase;
        phase = (age / (TICK_DIV / 2)) % 2;
        if (mode == M_EXPIRED) begin
            if (FLASH && phase == 1) return 8'hFF;
            return 8'h00;
        end
        tens = val / 10;
        return {(tens == 0) ? 4'hF : 4'(tens), 4'(val % 10)};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_val      = START_VAL;
            m_mode     = M_IDLE;
            m_frac     = 0;
            m_scan_age = 0;
            m_exp_age  = 0;
            {e_d1, e_d0} = show(START_VAL, M_IDLE, 0);
            e_scan  = 1'b0;
            e_run   = 1'b0;
            e_exp   = 1'b0;
            e_pulse = 1'b0;
        end else begin
            // Display reflects the situation before this edge.
            {e_d1, e_d0} = show(m_val, m_mode, m_exp_age);
            old_mode = m_mode;
            if (reload) begin
                m_val  = START_VAL;
                m_mode = M_IDLE;
                m_frac = 0;
            end else begin
                case (m_mode)
                    M_IDLE: if (start && !pause) begin
                        if (m_val == 0) m_mode = M_EXPIRED;
                        else begin
                            m_mode = M_RUN;
                            m_frac = 0;
                        end
                    end
                    M_RUN: if (pause) m_mode = M_PAUSED;
                           else begin
                               m_frac++;
                               if (m_frac == TICK_DIV) begin
                                   m_frac = 0;
                                   m_val--;
                                   if (m_val == 0) m_mode = M_EXPIRED;
                               end
                           end
                    M_PAUSED: if (start && !pause) m_mode = M_RUN;
                    default: ;
                endcase
            end
            if (m_mode == M_EXPIRED && old_mode == M_EXPIRED) m_exp_age++;
            else m_exp_age = 0;
            m_scan_age++;
            e_scan  = (m_scan_age % SCAN_DIV) == 0;
            e_run   = (m_mode == M_RUN);
            e_exp   = (m_mode == M_EXPIRED);
            e_pulse = (m_mode == M_EXPIRED) && (old_mode != M_EXPIRED);
        end
        m_valid = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("d1",           {4'h0, d1},          {4'h0, e_d1});
            check("d0",           {4'h0, d0},          {4'h0, e_d0});
            check("scan_en",      {7'h0, scan_en},     {7'h0, e_scan});
            check("running",      {7'h0, running},     {7'h0, e_run});
            check("expired",      {7'h0, expired},     {7'h0, e_exp});
            check("expire_pulse", {7'h0, expire_pulse}, {7'h0, e_pulse});
        end
    end

    // ---------------- driver tasks ----------------
    // Both tasks are entered and left just after a falling edge.
    task automatic pulse(input logic s, input logic p, input logic r);
        start  = s;
        pause  = p;
        reload = r;
        @(negedge clk);
        start  = 1'b0;
        pause  = 1'b0;
        reload = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed stimulus with literal pins ----------------
    initial begin
        repeat (5) @(negedge clk);
        rst = 1'b0;
        check("pin_reset_d1",      {4'h0, d1}, 8'h01);
        check("pin_reset_d0",      {4'h0, d0}, 8'h00);
        check("pin_reset_running", {7'h0, running}, 8'h00);

        // scan_en lands on the 4th edge after release
        idle(3);
        check("pin_scan_before", {7'h0, scan_en}, 8'h00);
        idle(1);
        check("pin_scan_first",  {7'h0, scan_en}, 8'h01);

        // Count down 10 -> 00; start sampled on edge S
        pulse(1'b1, 1'b0, 1'b0);
        check("pin_run_on", {7'h0, running}, 8'h01);
        idle(9);                               // past S+9: shows blank-9
        check("pin_09_d1", {4'h0, d1}, 8'h0F);
        check("pin_09_d0", {4'h0, d0}, 8'h09);
        idle(71);                              // past S+80: expiry edge
        check("pin_exp_flag",  {7'h0, expired},      8'h01);
        check("pin_exp_pulse", {7'h0, expire_pulse}, 8'h01);
        check("pin_exp_run",   {7'h0, running},      8'h00);
        idle(1);
        check("pin_exp_pulse_gone", {7'h0, expire_pulse}, 8'h00);
        check("pin_exp_d1", {4'h0, d1}, 8'h00);
        check("pin_exp_d0", {4'h0, d0}, 8'h00);
        pulse(1'b1, 1'b0, 1'b0);               // ignored in EXPIRED
        pulse(1'b0, 1'b1, 1'b0);               // ignored in EXPIRED
        idle(10);
        check("pin_exp_stays", {7'h0, expired}, 8'h01);
        check("pin_exp_norun", {7'h0, running}, 8'h00);

        // Pause three cycles into a second, hold, resume
        pulse(1'b0, 1'b0, 1'b1);
        idle(2);
        check("pin_reload_d1", {4'h0, d1}, 8'h01);
        check("pin_reload_expired", {7'h0, expired}, 8'h00);
        pulse(1'b0, 1'b1, 1'b0);               // pause in IDLE does nothing
        check("pin_idle_pause", {7'h0, running}, 8'h00);
        pulse(1'b1, 1'b0, 1'b0);               // edge S2
        idle(11);
        pulse(1'b0, 1'b1, 1'b0);               // sampled at S2+12, 3 cycles in
        idle(20);
        check("pin_paused_run", {7'h0, running}, 8'h00);
        check("pin_paused_d0",  {4'h0, d0}, 8'h09);
        pulse(1'b1, 1'b0, 1'b0);               // edge R
        idle(5);                               // past R+5: decrement just landed
        check("pin_resume_d0_old", {4'h0, d0}, 8'h09);
        idle(1);
        check("pin_resume_d0_new", {4'h0, d0}, 8'h08);

        // All three pulses together during RUN: reload wins
        idle(3);
        pulse(1'b1, 1'b1, 1'b1);
        check("pin_combo_run", {7'h0, running}, 8'h00);
        idle(1);
        check("pin_combo_d1", {4'h0, d1}, 8'h01);
        check("pin_combo_d0", {4'h0, d0}, 8'h00);

        // Pause and start together in PAUSED: pause wins, stays frozen
        pulse(1'b1, 1'b0, 1'b0);
        idle(4);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        idle(3);
        check("pin_paused_combo", {7'h0, running}, 8'h00);

        // Reset in the middle of a run
        pulse(1'b1, 1'b0, 1'b0);
        idle(12);
        rst = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);               // pending start must be dropped
        rst = 1'b0;
        check("pin_rst_mid_run", {7'h0, running}, 8'h00);
        check("pin_rst_mid_d1",  {4'h0, d1}, 8'h01);
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
